// File: rtl/cache_def.sv
// Shared d-cache / memory interface types: line geometry and the request/response structs.
package cache_def;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 128;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
      logic              rw;
      logic              valid;
   } mem_req_type;

   typedef struct packed {
      logic [LINE_W-1:0] data;
      logic              ready;
   } mem_data_type;
endpackage

// File: rtl/mem_line_array.sv
// Single-port line store: synchronous write, registered read of the addressed line every cycle.
module mem_line_array #(
   parameter int AW = 10,
   parameter int DW = 128
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] r_mem [2**AW];

   // Contents are deliberately not reset; simulation preloads them if needed.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[addr_i] <= wdata_i;
      end
      rdata_o <= r_mem[addr_i];
   end
endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder for the d-cache refill/write-back port: one line request at a time,
// fixed LATENCY cycles from accept to a one-cycle ready pulse, then a GAP cycle before the next accept.
module main_mem_responder
   import cache_def::*;
#(
   parameter int LATENCY  = 8,
   parameter int MEM_AW   = 10,
   parameter int LINE_OFF = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  mem_req_type  mem_req_i,
   output mem_data_type mem_data_o,
   output logic         busy_o,
   output logic [31:0]  no_rd_o,
   output logic [31:0]  no_wr_o
);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CW-1:0]     r_cnt;
   logic [MEM_AW-1:0] r_line;
   logic [LINE_W-1:0] r_wdata;
   logic              r_rw;
   logic [LINE_W-1:0] r_data;
   logic [MEM_AW-1:0] w_req_line;
   logic [MEM_AW-1:0] w_arr_line;
   logic [LINE_W-1:0] w_rdata;
   logic [LINE_W-1:0] w_resp_data;
   logic              w_accept;
   logic              w_we;
   logic              w_unused_addr;

   assign w_req_line    = mem_req_i.addr[LINE_OFF+MEM_AW-1:LINE_OFF];
   assign w_unused_addr = ^{mem_req_i.addr[ADDR_W-1:LINE_OFF+MEM_AW], mem_req_i.addr[LINE_OFF-1:0]};
   assign w_accept      = (r_state == IDLE) && mem_req_i.valid;
   // In IDLE the array looks at the live address so a LATENCY==1 read has its line ready in RESP.
   assign w_arr_line    = (r_state == IDLE) ? w_req_line : r_line;
   assign w_we          = (r_state == RESP) && r_rw;
   assign w_resp_data   = r_rw ? r_wdata : w_rdata;

   mem_line_array #(
      .AW (MEM_AW),
      .DW (LINE_W)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (w_we),
      .addr_i  (w_arr_line),
      .wdata_i (r_wdata),
      .rdata_o (w_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // BUSY lasts LATENCY-1 cycles so that RESP is the LATENCY-th cycle after accept.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (mem_req_i.valid) w_next = (LATENCY == 1) ? RESP : BUSY;
         BUSY:    if (r_cnt == CW'(1)) w_next = RESP;
         RESP:    w_next = GAP;
         GAP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      mem_data_o.ready = 1'b0;
      mem_data_o.data  = r_data;
      busy_o           = 1'b0;
      case (r_state)
         BUSY: busy_o = 1'b1;
         RESP: begin
            mem_data_o.ready = 1'b1;
            mem_data_o.data  = w_resp_data;
            busy_o           = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_line  <= '0;
         r_wdata <= '0;
         r_rw    <= 1'b0;
         r_data  <= '0;
         no_rd_o <= '0;
         no_wr_o <= '0;
      end else begin
         if (w_accept) begin
            r_line  <= w_req_line;
            r_wdata <= mem_req_i.data;
            r_rw    <= mem_req_i.rw;
            r_cnt   <= CW'(LATENCY - 1);
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (r_state == RESP) begin
            r_data <= w_resp_data;
            if (r_rw) begin
               no_wr_o <= no_wr_o + 32'd1;
            end else begin
               no_rd_o <= no_rd_o + 32'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench: one LATENCY=8 and one LATENCY=1 responder, expected responses queued at issue.
module tb_main_mem_responder;
   import cache_def::*;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   mem_req_type  req0, req1;
   mem_data_type rsp0, rsp1;
   logic         busy0, busy1;
   logic [31:0]  nrd0, nwr0, nrd1, nwr1;

   main_mem_responder #(.LATENCY(8), .MEM_AW(10), .LINE_OFF(4)) u0 (
      .clk_i(clk), .rst_i(rst), .mem_req_i(req0), .mem_data_o(rsp0),
      .busy_o(busy0), .no_rd_o(nrd0), .no_wr_o(nwr0));

   main_mem_responder #(.LATENCY(1), .MEM_AW(10), .LINE_OFF(4)) u1 (
      .clk_i(clk), .rst_i(rst), .mem_req_i(req1), .mem_data_o(rsp1),
      .busy_o(busy1), .no_rd_o(nrd1), .no_wr_o(nwr1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] data;
      int           cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   nerr = 0;
   int   nchk = 0;
   int   next_ok[2];
   int   lat[2] = '{8, 1};

   localparam logic [127:0] D_ONES = {4{32'h1111_1111}};
   localparam logic [127:0] D_A    = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
   localparam logic [127:0] D_B    = 128'h0BAD_F00D_1234_5678_9ABC_DEF0_CAFE_BEEF;
   localparam logic [127:0] D_C    = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
   localparam logic [127:0] D_0    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] D_E    = 128'hEEEE_0000_EEEE_1111_EEEE_2222_EEEE_3333;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rsp0.ready === 1'b1) begin
         if (q0.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL u0 unexpected ready: got ready at cycle %0d expected none", cyc);
         end else begin
            e = q0.pop_front();
            check("u0 data", rsp0.data, e.data);
            check("u0 ready cycle", 128'(cyc), 128'(e.cyc));
         end
      end
      if (rsp1.ready === 1'b1) begin
         if (q1.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL u1 unexpected ready: got ready at cycle %0d expected none", cyc);
         end else begin
            e = q1.pop_front();
            check("u1 data", rsp1.data, e.data);
            check("u1 ready cycle", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   task automatic drive(input int idx, input mem_req_type r);
      if (idx == 0) req0 = r;
      else          req1 = r;
   endtask

   // Called on a negedge; returns on the negedge of the expected ready cycle with the request still driven.
   task automatic txn(input int idx, input logic [31:0] addr, input logic [127:0] wd,
                      input logic rw, input logic [127:0] expd, input bit scramble);
      int          acc;
      mem_req_type r;
      exp_t        e;
      acc = (cyc + 1 > next_ok[idx]) ? cyc + 1 : next_ok[idx];
      r = '{addr: addr, data: wd, rw: rw, valid: 1'b1};
      drive(idx, r);
      e.data = expd;
      e.cyc  = acc + lat[idx] - 1;
      if (idx == 0) q0.push_back(e);
      else          q1.push_back(e);
      next_ok[idx] = acc + lat[idx] + 2;
      while (cyc < acc) @(negedge clk);
      if (scramble) begin
         r.addr  = ~addr;
         r.data  = ~wd;
         r.rw    = ~rw;
         r.valid = 1'b0;
         drive(idx, r);
      end
      while (cyc < acc + lat[idx] - 1) @(negedge clk);
   endtask

   initial begin
      req0 = '0;
      req1 = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset ready", 128'(rsp0.ready), 128'(0));
      check("reset data", rsp0.data, 128'(0));
      check("reset busy", 128'(busy0), 128'(0));
      check("reset no_rd", 128'(nrd0), 128'(0));
      check("reset no_wr", 128'(nwr0), 128'(0));
      next_ok[0] = cyc + 1;
      next_ok[1] = cyc + 1;

      txn(0, 32'h0000_0040, D_ONES, 1'b1, D_ONES, 1'b0);
      txn(0, 32'h0000_0040, '0, 1'b0, D_ONES, 1'b0);
      req0.valid = 1'b0;
      @(negedge clk);
      check("no_wr after first pair", 128'(nwr0), 128'(1));
      check("no_rd after first pair", 128'(nrd0), 128'(1));

      txn(0, 32'h0000_0200, D_0, 1'b1, D_0, 1'b0);
      txn(0, 32'h0000_0080, D_A, 1'b1, D_A, 1'b0);
      txn(0, 32'h0000_4080, '0, 1'b0, D_A, 1'b0);
      txn(0, 32'h0000_0100, D_B, 1'b1, D_B, 1'b1);
      txn(0, 32'h0000_010C, '0, 1'b0, D_B, 1'b1);
      req0.valid = 1'b0;
      @(negedge clk);
      check("no_wr after sequence", 128'(nwr0), 128'(4));
      check("no_rd after sequence", 128'(nrd0), 128'(3));

      // Write to 0x200 aborted by reset while BUSY; the earlier D_0 must survive.
      while (cyc < next_ok[0]) @(negedge clk);
      req0 = '{addr: 32'h0000_0200, data: D_C, rw: 1'b1, valid: 1'b1};
      @(negedge clk);
      req0.valid = 1'b0;
      repeat (3) @(negedge clk);
      check("busy mid-transaction", 128'(busy0), 128'(1));
      rst = 1'b1;
      #1;
      check("mid reset ready", 128'(rsp0.ready), 128'(0));
      check("mid reset busy", 128'(busy0), 128'(0));
      check("mid reset data", rsp0.data, 128'(0));
      check("mid reset no_wr", 128'(nwr0), 128'(0));
      check("mid reset no_rd", 128'(nrd0), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      next_ok[0] = cyc + 1;
      next_ok[1] = cyc + 1;
      txn(0, 32'h0000_0200, '0, 1'b0, D_0, 1'b0);
      req0.valid = 1'b0;
      @(negedge clk);
      check("no_rd after reset read", 128'(nrd0), 128'(1));
      check("no_wr after aborted write", 128'(nwr0), 128'(0));

      txn(1, 32'h0000_0030, D_E, 1'b1, D_E, 1'b0);
      txn(1, 32'h0000_0030, '0, 1'b0, D_E, 1'b0);
      req1.valid = 1'b0;
      repeat (4) @(negedge clk);
      check("u1 no_wr", 128'(nwr1), 128'(1));
      check("u1 no_rd", 128'(nrd1), 128'(1));

      repeat (12) @(negedge clk);
      check("u0 responses outstanding", 128'(q0.size()), 128'(0));
      check("u1 responses outstanding", 128'(q1.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
